mac_operand_sequencer: RTL and testbench
========================================

Name: mac_operand_sequencer

Overview:
Upstream feeder for the 4-bit MAC unit. Holds one matrix row (A) and one column (B) of LEN 4-bit elements. On start, drives the MAC's w/x/load/clear pins with the timing the MAC needs: product registered on posedge, accumulated on negedge. Captures the 8-bit dot product from the MAC output and flags completion. One instance per MAC in the matrix-multiply array.

Parameters:
LEN, 4, elements per dot product (row/column length); legal range 1..16
DW, 4, operand width; fixed by the MAC
RW, 8, result width; fixed by the MAC accumulator
AW, $clog2(LEN) (min 1), element address width

Ports:
clk  in  1  clock; all state updates on posedge
clr  in  1  synchronous active-high reset
wr_en  in  1  element write strobe
wr_addr  in  AW  element index
wr_a  in  DW  row element A[wr_addr]
wr_b  in  DW  column element B[wr_addr]
start  in  1  begin dot product (single-cycle pulse or level)
busy  out  1  sequence in progress
done  out  1  one-cycle pulse when result is valid
w_o  out  DW  to MAC w
x_o  out  DW  to MAC x
load_o  out  1  to MAC load
clear_o  out  1  to MAC clear
mac_o  in  RW  from MAC o
result  out  RW  captured dot product

Behaviour:
- Reset (clr=1 at posedge): state IDLE. busy=0, done=0, w_o=0, x_o=0, load_o=0, result=0, A/B storage=0. clear_o=1 while clr is high, so the downstream accumulator is also cleared.
- Writes: at a posedge with wr_en=1, state IDLE and wr_addr<LEN, write A[wr_addr]=wr_a and B[wr_addr]=wr_b. Otherwise the write is ignored. Writes in any non-IDLE state are ignored.
- FSM states: IDLE -> CLEAR -> STREAM -> DRAIN -> FLUSH -> IDLE.
- Cycle numbering: cycle 0 is the cycle in which start=1 is sampled in IDLE.
- Cycle 1 (CLEAR): clear_o=1, load_o=0, busy=1.
- Cycles 2..LEN+1 (STREAM): w_o=A[i], x_o=B[i] for i=0..LEN-1, with a 4-bit index counter.
- load_o is a one-cycle-delayed copy of "operand valid": high in cycles 3..LEN+2. Cycle LEN+2 is DRAIN, with w_o=x_o=0.
- Rationale: the MAC registers the product on the posedge after operands appear, then adds on the following negedge. load_o must therefore cover the cycle after each operand pair.
- FLUSH (cycle LEN+3): result<=mac_o is captured at the posedge entering FLUSH. done=1 for exactly this cycle, busy=0, load_o=0. Next state is IDLE.
- start while busy, or in FLUSH: ignored, with no queuing. start held high in IDLE: a new sequence begins the cycle after FLUSH.
- result holds its value until the next FLUSH or reset.
- Arithmetic: result is the MAC's 8-bit sum, i.e. sum(A[i]*B[i]) mod 256. Overflow is not flagged.
- clr mid-sequence (any state): the above reset values apply at that posedge. No done pulse. A partial result is never captured.
- LEN=1: STREAM lasts 1 cycle; done is in cycle 4.
- Total latency, start to done: LEN+3 cycles.

Decomposition:
- Shared package:
  - DW=4 and RW=8 constants
  - FSM state enum (IDLE, CLEAR, STREAM, DRAIN, FLUSH; 3-bit)
- Sub-module: mac_operand_rf. LEN x (2*DW) register file with one write port, one combinational read port, and synchronous clr to zero.
- The FSM, index counter, load_o delay flop and result register live in the top.

Test Plan:
- Reset and idle: after reset, outputs are 0 and clear_o=1 while clr=1. start with no writes, with the downstream MAC attached -> done at cycle 7, result=0.
- Basic dot product: write A={1,2,3,4}, B={1,2,3,4}, then start -> w_o/x_o=1..4 in cycles 2..5, load_o high in cycles 3..6, done at cycle 7, result=30 (0x1E).
- Overflow wrap: A=B={15,15,15,15} -> result=900 mod 256=132 (0x84). A back-to-back run with A={2,0,0,0}, B={3,0,0,0} -> result=6, proving clear_o works between runs.
- Ignored events: wr_en during STREAM with wr_addr=0, wr_a=9 -> current result is unaffected and A[0] is unchanged on the next run. start pulse during busy -> no extra done.
- Reset mid-operation: assert clr in cycle 4 -> busy=0 next cycle, no done, result=0. A subsequent start gives a result of 0, since storage was cleared.
- LEN=1 build: A[0]=7, B[0]=5 -> done at cycle 4, result=35.

Source files
------------

// File: rtl/mac_operand_sequencer_pkg.sv
// Shared constants, FSM encoding and operand storage layout for the MAC operand sequencer.
package mac_operand_sequencer_pkg;

    localparam int unsigned DW   = 4;
    localparam int unsigned RW   = 8;
    localparam int unsigned IDXW = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_FLUSH  = 3'd4
    } state_e;

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } operand_pair_t;

    // Element address width; a single-element build still needs one address bit.
    function automatic int unsigned addr_width(input int unsigned len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

endpackage

// File: rtl/mac_operand_sequencer_if.sv
// Host/MAC-facing signal bundle of one sequencer; slave is the sequencer side.
interface mac_operand_sequencer_if #(
    parameter int unsigned LEN = 4
);
    import mac_operand_sequencer_pkg::*;

    localparam int unsigned AW = addr_width(LEN);

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_a;
    logic [DW-1:0] wr_b;
    logic          start;
    logic          busy;
    logic          done;
    logic [DW-1:0] w_o;
    logic [DW-1:0] x_o;
    logic          load_o;
    logic          clear_o;
    logic [RW-1:0] mac_o;
    logic [RW-1:0] result;

    modport slave (
        input  wr_en, wr_addr, wr_a, wr_b, start, mac_o,
        output busy, done, w_o, x_o, load_o, clear_o, result
    );

    modport master (
        output wr_en, wr_addr, wr_a, wr_b, start, mac_o,
        input  busy, done, w_o, x_o, load_o, clear_o, result
    );

endinterface

// File: rtl/mac_operand_sequencer_rf.sv
// LEN-deep storage of (A, B) operand pairs: one write port, one combinational read port.
module mac_operand_rf
    import mac_operand_sequencer_pkg::*;
#(
    parameter int unsigned LEN = 4,
    parameter int unsigned AW  = 2
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  operand_pair_t i_wdata,
    input  logic [AW-1:0] i_raddr,
    output operand_pair_t o_rdata
);

    operand_pair_t r_mem [LEN];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int unsigned i = 0; i < LEN; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mac_operand_sequencer.sv
// Streams stored A/B operand pairs into a 4-bit MAC and captures the 8-bit dot product.
module mac_operand_sequencer
    import mac_operand_sequencer_pkg::*;
#(
    parameter int unsigned LEN = 4
) (
    input  logic                    clk,
    input  logic                    clr,
    mac_operand_sequencer_if.slave  bus
);

    localparam int unsigned   AW       = addr_width(LEN);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(LEN - 1);

    state_e          r_state;
    state_e          w_next_state;
    logic [IDXW-1:0] r_idx;
    logic            r_load;
    logic [RW-1:0]   r_result;

    logic            w_wr_en;
    operand_pair_t   w_wdata;
    operand_pair_t   w_rd;
    logic            w_busy;
    logic            w_done;
    logic            w_clear;
    logic [DW-1:0]   w_w;
    logic [DW-1:0]   w_x;

    // Storage is only writable while idle so a running sequence never sees torn operands.
    assign w_wr_en       = bus.wr_en && (r_state == ST_IDLE) && (32'(bus.wr_addr) < LEN);
    assign w_wdata.a     = bus.wr_a;
    assign w_wdata.b     = bus.wr_b;

    mac_operand_rf #(
        .LEN (LEN),
        .AW  (AW)
    ) u_rf (
        .clk     (clk),
        .clr     (clr),
        .i_we    (w_wr_en),
        .i_waddr (bus.wr_addr),
        .i_wdata (w_wdata),
        .i_raddr (AW'(r_idx)),
        .o_rdata (w_rd)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE:   if (bus.start) w_next_state = ST_CLEAR;
            ST_CLEAR:  w_next_state = ST_STREAM;
            ST_STREAM: if (r_idx == LAST_IDX) w_next_state = ST_DRAIN;
            ST_DRAIN:  w_next_state = ST_FLUSH;
            ST_FLUSH:  w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // clear_o follows clr directly so the downstream accumulator resets alongside us.
    always_comb begin
        w_busy  = 1'b0;
        w_done  = 1'b0;
        w_clear = clr;
        w_w     = '0;
        w_x     = '0;
        unique case (r_state)
            ST_CLEAR: begin
                w_busy  = 1'b1;
                w_clear = 1'b1;
            end
            ST_STREAM: begin
                w_busy = 1'b1;
                w_w    = w_rd.a;
                w_x    = w_rd.b;
            end
            ST_DRAIN: w_busy = 1'b1;
            ST_FLUSH: w_done = 1'b1;
            default: ;
        endcase
    end

    // load_o lags operand-valid by one cycle: the MAC registers the product first, then adds.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_idx    <= '0;
            r_load   <= 1'b0;
            r_result <= '0;
        end else begin
            r_load <= (r_state == ST_STREAM);
            if (r_state == ST_CLEAR) begin
                r_idx <= '0;
            end else if (r_state == ST_STREAM) begin
                r_idx <= r_idx + IDXW'(1);
            end
            if (r_state == ST_DRAIN) begin
                r_result <= bus.mac_o;
            end
        end
    end

    assign bus.busy    = w_busy;
    assign bus.done    = w_done;
    assign bus.clear_o = w_clear;
    assign bus.w_o     = w_w;
    assign bus.x_o     = w_x;
    assign bus.load_o  = r_load;
    assign bus.result  = r_result;

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Bench for mac_operand_sequencer: LEN=4 and LEN=1 instances, each driving a behavioural MAC.
module tb_mac_operand_sequencer;
    import mac_operand_sequencer_pkg::*;

    localparam int unsigned LEN  = 4;
    localparam int unsigned LEN1 = 1;

    logic clk = 1'b0;
    logic clr;
    int   total = 0;
    int   bad   = 0;

    logic [7:0] sb4 [$];
    logic [7:0] sb1 [$];
    logic [3:0] ma [LEN];
    logic [3:0] mb [LEN];
    logic [3:0] ma1;
    logic [3:0] mb1;

    always #5 clk = ~clk;

    mac_operand_sequencer_if #(.LEN(LEN))  bus4();
    mac_operand_sequencer_if #(.LEN(LEN1)) bus1();

    mac_operand_sequencer #(.LEN(LEN)) dut4 (
        .clk (clk),
        .clr (clr),
        .bus (bus4)
    );

    mac_operand_sequencer #(.LEN(LEN1)) dut1 (
        .clk (clk),
        .clr (clr),
        .bus (bus1)
    );

    // Behavioural MAC: product on posedge, accumulate on negedge.
    logic [7:0] prod4 = 8'd0;
    logic [7:0] acc4  = 8'd0;
    logic [7:0] prod1 = 8'd0;
    logic [7:0] acc1  = 8'd0;

    always @(posedge clk) prod4 <= 8'(bus4.w_o) * 8'(bus4.x_o);
    always @(negedge clk) begin
        if (bus4.clear_o) acc4 <= 8'd0;
        else if (bus4.load_o) acc4 <= acc4 + prod4;
    end
    assign bus4.mac_o = acc4;

    always @(posedge clk) prod1 <= 8'(bus1.w_o) * 8'(bus1.x_o);
    always @(negedge clk) begin
        if (bus1.clear_o) acc1 <= 8'd0;
        else if (bus1.load_o) acc1 <= acc1 + prod1;
    end
    assign bus1.mac_o = acc1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_models();
        for (int i = 0; i < int'(LEN); i++) begin
            ma[i] = 4'd0;
            mb[i] = 4'd0;
        end
        ma1 = 4'd0;
        mb1 = 4'd0;
    endtask

    function automatic logic [7:0] model_sum4();
        logic [7:0] s;
        s = 8'd0;
        for (int i = 0; i < int'(LEN); i++) s = s + 8'(ma[i]) * 8'(mb[i]);
        return s;
    endfunction

    task automatic wr4(input int unsigned addr, input logic [3:0] a, input logic [3:0] b);
        bus4.wr_en   = 1'b1;
        bus4.wr_addr = 2'(addr);
        bus4.wr_a    = a;
        bus4.wr_b    = b;
        tick();
        bus4.wr_en = 1'b0;
        ma[addr]   = a;
        mb[addr]   = b;
    endtask

    task automatic wr1(input int unsigned addr, input logic [3:0] a, input logic [3:0] b);
        bus1.wr_en   = 1'b1;
        bus1.wr_addr = 1'(addr);
        bus1.wr_a    = a;
        bus1.wr_b    = b;
        tick();
        bus1.wr_en = 1'b0;
        if (addr < LEN1) begin
            ma1 = a;
            mb1 = b;
        end
    endtask

    // Called in cycle 1; returns the cycle number where done was seen (bounded).
    task automatic wait_done(input bit sel, output int c);
        c = 1;
        while (((sel ? bus1.done : bus4.done) !== 1'b1) && c < 40) begin
            tick();
            c++;
        end
    endtask

    task automatic start4();
        bus4.start = 1'b1;
        tick();
        bus4.start = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        tick();
        tick();
        total++; if (bus4.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus4.busy); end
        total++; if (bus4.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus4.done); end
        total++; if (bus4.w_o !== 4'd0 || bus4.x_o !== 4'd0) begin bad++; $display("FAIL reset_wx got=%h/%h want=0/0", bus4.w_o, bus4.x_o); end
        total++; if (bus4.load_o !== 1'b0) begin bad++; $display("FAIL reset_load got=%b want=0", bus4.load_o); end
        total++; if (bus4.result !== 8'd0) begin bad++; $display("FAIL reset_result got=%h want=00", bus4.result); end
        total++; if (bus4.clear_o !== 1'b1) begin bad++; $display("FAIL reset_clear4 got=%b want=1", bus4.clear_o); end
        total++; if (bus1.clear_o !== 1'b1) begin bad++; $display("FAIL reset_clear1 got=%b want=1", bus1.clear_o); end
        clr = 1'b0;
        clear_models();
        tick();
        total++; if (bus4.clear_o !== 1'b0) begin bad++; $display("FAIL idle_clear4 got=%b want=0", bus4.clear_o); end
        total++; if (bus1.result !== 8'd0) begin bad++; $display("FAIL reset_result1 got=%h want=00", bus1.result); end
    endtask

    task automatic test_idle_start();
        int c;
        logic [7:0] exp_r;
        sb4.push_back(model_sum4());
        start4();
        wait_done(1'b0, c);
        total++; if (c != 7) begin bad++; $display("FAIL idle_done_cycle got=%0d want=7", c); end
        exp_r = sb4.pop_front();
        total++; if (bus4.result !== exp_r) begin bad++; $display("FAIL idle_result got=%h want=%h", bus4.result, exp_r); end
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] exp_r;
        for (int i = 0; i < 4; i++) wr4(i, 4'(i + 1), 4'(i + 1));
        sb4.push_back(model_sum4());
        start4();
        for (int c = 1; c <= 7; c++) begin
            logic [3:0] ew;
            logic el;
            logic eb;
            logic ed;
            ew = (c >= 2 && c <= 5) ? 4'(c - 1) : 4'd0;
            el = (c >= 3 && c <= 6);
            eb = (c >= 1 && c <= 6);
            ed = (c == 7);
            total++; if (bus4.w_o !== ew || bus4.x_o !== ew) begin bad++; $display("FAIL basic_wx c%0d got=%h/%h want=%h", c, bus4.w_o, bus4.x_o, ew); end
            total++; if (bus4.load_o !== el) begin bad++; $display("FAIL basic_load c%0d got=%b want=%b", c, bus4.load_o, el); end
            total++; if (bus4.busy !== eb || bus4.done !== ed) begin bad++; $display("FAIL basic_busydone c%0d got=%b%b want=%b%b", c, bus4.busy, bus4.done, eb, ed); end
            total++; if ((c == 1 || c == 7) && bus4.clear_o !== (c == 1)) begin bad++; $display("FAIL basic_clear c%0d got=%b", c, bus4.clear_o); end
            if (c == 7) begin
                exp_r = sb4.pop_front();
                total++; if (bus4.result !== exp_r) begin bad++; $display("FAIL basic_result got=%h want=%h", bus4.result, exp_r); end
            end else begin
                tick();
            end
        end
        tick();
    endtask

    task automatic test_overflow();
        int c;
        logic [7:0] exp_r;
        for (int i = 0; i < 4; i++) wr4(i, 4'd15, 4'd15);
        sb4.push_back(model_sum4());
        start4();
        wait_done(1'b0, c);
        exp_r = sb4.pop_front();
        total++; if (bus4.result !== exp_r || exp_r !== 8'h84) begin bad++; $display("FAIL ovf_result got=%h want=84", bus4.result); end
        tick();
        wr4(0, 4'd2, 4'd3);
        for (int i = 1; i < 4; i++) wr4(i, 4'd0, 4'd0);
        sb4.push_back(model_sum4());
        start4();
        wait_done(1'b0, c);
        total++; if (c != 7) begin bad++; $display("FAIL rerun_done_cycle got=%0d want=7", c); end
        exp_r = sb4.pop_front();
        total++; if (bus4.result !== exp_r) begin bad++; $display("FAIL rerun_result got=%h want=%h", bus4.result, exp_r); end
        tick();
    endtask

    task automatic test_back_to_back();
        int c;
        logic [7:0] exp_r;
        for (int i = 0; i < 4; i++) wr4(i, 4'(i + 1), 4'(4 - i));
        sb4.push_back(model_sum4());
        sb4.push_back(model_sum4());
        bus4.start = 1'b1;
        tick();
        wait_done(1'b0, c);
        total++; if (c != 7) begin bad++; $display("FAIL b2b_first_cycle got=%0d want=7", c); end
        exp_r = sb4.pop_front();
        total++; if (bus4.result !== exp_r) begin bad++; $display("FAIL b2b_first_result got=%h want=%h", bus4.result, exp_r); end
        tick();
        wait_done(1'b0, c);
        bus4.start = 1'b0;
        total++; if (c != 8) begin bad++; $display("FAIL b2b_gap got=%0d want=8", c); end
        exp_r = sb4.pop_front();
        total++; if (bus4.result !== exp_r) begin bad++; $display("FAIL b2b_second_result got=%h want=%h", bus4.result, exp_r); end
        tick();
        tick();
        total++; if (bus4.busy !== 1'b0) begin bad++; $display("FAIL b2b_no_third got=%b want=0", bus4.busy); end
    endtask

    task automatic test_ignored();
        int ndone;
        int c;
        logic [7:0] exp_r;
        logic [7:0] got_r;
        sb4.push_back(model_sum4());
        start4();
        tick();
        tick();
        bus4.wr_en   = 1'b1;
        bus4.wr_addr = 2'd0;
        bus4.wr_a    = 4'd9;
        bus4.wr_b    = 4'd9;
        tick();
        bus4.wr_en = 1'b0;
        bus4.start = 1'b1;
        tick();
        bus4.start = 1'b0;
        ndone = 0;
        got_r = 8'd0;
        for (int k = 5; k < 22; k++) begin
            if (bus4.done === 1'b1) begin
                ndone++;
                got_r = bus4.result;
            end
            tick();
        end
        total++; if (ndone != 1) begin bad++; $display("FAIL ign_done_count got=%0d want=1", ndone); end
        exp_r = sb4.pop_front();
        total++; if (got_r !== exp_r) begin bad++; $display("FAIL ign_result got=%h want=%h", got_r, exp_r); end
        sb4.push_back(model_sum4());
        start4();
        wait_done(1'b0, c);
        exp_r = sb4.pop_front();
        total++; if (bus4.result !== exp_r) begin bad++; $display("FAIL ign_rerun_result got=%h want=%h", bus4.result, exp_r); end
        tick();
    endtask

    task automatic test_reset_mid();
        int ndone;
        int c;
        logic [7:0] exp_r;
        start4();
        tick();
        tick();
        tick();
        clr = 1'b1;
        tick();
        total++; if (bus4.busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b want=0", bus4.busy); end
        total++; if (bus4.result !== 8'd0) begin bad++; $display("FAIL mid_result got=%h want=00", bus4.result); end
        total++; if (bus4.clear_o !== 1'b1 || bus4.load_o !== 1'b0) begin bad++; $display("FAIL mid_clear_load got=%b%b want=10", bus4.clear_o, bus4.load_o); end
        clr = 1'b0;
        clear_models();
        ndone = 0;
        for (int k = 0; k < 10; k++) begin
            if (bus4.done === 1'b1) ndone++;
            tick();
        end
        total++; if (ndone != 0) begin bad++; $display("FAIL mid_no_done got=%0d want=0", ndone); end
        sb4.push_back(model_sum4());
        start4();
        wait_done(1'b0, c);
        total++; if (c != 7) begin bad++; $display("FAIL mid_rerun_cycle got=%0d want=7", c); end
        exp_r = sb4.pop_front();
        total++; if (bus4.result !== exp_r) begin bad++; $display("FAIL mid_rerun_result got=%h want=%h", bus4.result, exp_r); end
        tick();
    endtask

    task automatic test_len1();
        logic [7:0] exp_r;
        wr1(1, 4'd9, 4'd9);
        wr1(0, 4'd7, 4'd5);
        sb1.push_back(8'(ma1) * 8'(mb1));
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            logic [3:0] ew;
            logic el;
            ew = (c == 2) ? 4'd7 : 4'd0;
            el = (c == 3);
            total++; if (bus1.w_o !== ew) begin bad++; $display("FAIL len1_w c%0d got=%h want=%h", c, bus1.w_o, ew); end
            total++; if (bus1.load_o !== el || bus1.done !== (c == 4)) begin bad++; $display("FAIL len1_loaddone c%0d got=%b%b", c, bus1.load_o, bus1.done); end
            if (c == 4) begin
                exp_r = sb1.pop_front();
                total++; if (bus1.result !== exp_r || exp_r !== 8'd35) begin bad++; $display("FAIL len1_result got=%h want=23", bus1.result); end
            end else begin
                tick();
            end
        end
        tick();
    endtask

    initial begin
        clr          = 1'b1;
        bus4.wr_en   = 1'b0;
        bus4.wr_addr = '0;
        bus4.wr_a    = 4'd0;
        bus4.wr_b    = 4'd0;
        bus4.start   = 1'b0;
        bus1.wr_en   = 1'b0;
        bus1.wr_addr = '0;
        bus1.wr_a    = 4'd0;
        bus1.wr_b    = 4'd0;
        bus1.start   = 1'b0;
        clear_models();
        test_reset();
        test_idle_start();
        test_basic();
        test_overflow();
        test_back_to_back();
        test_ignored();
        test_reset_mid();
        test_len1();
        total++; if (sb4.size() != 0 || sb1.size() != 0) begin bad++; $display("FAIL scoreboard_left got=%0d/%0d want=0/0", sb4.size(), sb1.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
